// File: rtl/alu_seq_pkg.sv
// Shared opcode encoding, FSM states and sizing helper for the multi-cycle ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADDU = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUBU = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step counter width: CNTW = $clog2(N)+1, wide enough to hold N itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared N-step engine: shift-add multiply or restoring shift-subtract divide.
// The first step is taken on the start edge so the result is ready N cycles later.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           op_div,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] res
);

  localparam int CNTW = cnt_w(N);

  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  acc_src;
  logic [2*N-1:0]  acc_nxt;
  logic [N-1:0]    opnd_q;
  logic [N-1:0]    opnd_src;
  logic            div_q;
  logic            div_src;
  logic [CNTW-1:0] cnt;
  logic            busy;

  // Upper half accumulates the product; lower half shifts out multiplier bits.
  function automatic logic [2*N-1:0] mul_step(input logic [2*N-1:0] p,
                                               input logic [N-1:0]   m);
    logic [N:0] sum;
    sum = {1'b0, p[2*N-1:N]} + (p[0] ? {1'b0, m} : {(N+1){1'b0}});
    return {sum, p[N-1:1]};
  endfunction

  // Upper half is the partial remainder; quotient bits shift in at the bottom.
  function automatic logic [2*N-1:0] div_step(input logic [2*N-1:0] p,
                                              input logic [N-1:0]   d);
    logic [N:0]   trial;
    logic [N:0]   diff;
    logic [N-1:0] rem;
    logic         q;
    trial = {p[2*N-1:N], p[N-1]};
    diff  = trial - {1'b0, d};
    q     = ~diff[N];
    rem   = q ? diff[N-1:0] : trial[N-1:0];
    return {rem, p[N-2:0], q};
  endfunction

  always_comb begin
    acc_src  = start ? {{N{1'b0}}, a} : acc;
    opnd_src = start ? b : opnd_q;
    div_src  = start ? op_div : div_q;
    acc_nxt  = div_src ? div_step(acc_src, opnd_src) : mul_step(acc_src, opnd_src);
  end

  assign done = busy && (cnt == CNTW'(1));
  assign res  = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= acc_nxt;
      opnd_q <= b;
      div_q  <= op_div;
      cnt    <= CNTW'(N);
      busy   <= 1'b1;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt - CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle add/sub/logic/compare,
// iterative unsigned multiply, divide and remainder.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N    = 32,
  parameter int CTRW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    A,
  input  logic [N-1:0]    B,
  input  logic [CTRW-1:0] ALUctr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    Result,
  output logic            Zero,
  output logic            Overflow
);

  state_t          state;
  state_t          state_nxt;
  logic [CTRW-1:0] op_q;
  logic            needs_iter;
  logic            iter_start;
  logic            iter_done;
  logic [2*N-1:0]  iter_res;
  logic            res_load;
  logic [N-1:0]    res_nxt;
  logic            ovf_nxt;

  function automatic logic add_ovf(input logic signed [N-1:0] a,
                                   input logic signed [N-1:0] b,
                                   input logic signed [N-1:0] s);
    return (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [N-1:0] a,
                                   input logic signed [N-1:0] b,
                                   input logic signed [N-1:0] d);
    return (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
  endfunction

  // {Overflow, Result} for everything finished in the accept cycle, including
  // divide-by-zero; SLT uses a true signed compare so subtract overflow cannot leak in.
  function automatic logic [N:0] fast_op(input logic [CTRW-1:0]     ctr,
                                         input logic signed [N-1:0] a,
                                         input logic signed [N-1:0] b);
    logic signed [N-1:0] sum;
    logic signed [N-1:0] diff;
    logic [N:0]          r;
    sum  = a + b;
    diff = a - b;
    r    = '0;
    case (ctr)
      OP_ADDU: r = {1'b0, sum};
      OP_ADD:  r = {add_ovf(a, b, sum), sum};
      OP_SUBU: r = {1'b0, diff};
      OP_SUB:  r = {sub_ovf(a, b, diff), diff};
      OP_OR:   r = {1'b0, a | b};
      OP_SLT:  r = {1'b0, {(N-1){1'b0}}, (a < b)};
      OP_SLTU: r = {1'b0, {(N-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      OP_AND:  r = {1'b0, a & b};
      OP_DIVU: r = {1'b1, {N{1'b1}}};
      OP_REMU: r = {1'b1, a};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign needs_iter = (ALUctr == OP_MULU) ||
                      (((ALUctr == OP_DIVU) || (ALUctr == OP_REMU)) && (B != '0));

  alu_seq_iter #(
    .N (N)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start),
    .op_div (ALUctr != OP_MULU),
    .a      (A),
    .b      (B),
    .done   (iter_done),
    .res    (iter_res)
  );

  always_comb begin
    state_nxt  = state;
    iter_start = 1'b0;
    res_load   = 1'b0;
    res_nxt    = Result;
    ovf_nxt    = Overflow;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (needs_iter) begin
            iter_start = 1'b1;
            state_nxt  = ST_CALC;
          end else begin
            res_load             = 1'b1;
            {ovf_nxt, res_nxt}   = fast_op(ALUctr, A, B);
            state_nxt            = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        if (iter_done) begin
          res_load  = 1'b1;
          state_nxt = ST_DONE;
          case (op_q)
            OP_MULU: begin
              res_nxt = iter_res[N-1:0];
              ovf_nxt = |iter_res[2*N-1:N];
            end
            OP_DIVU: begin
              res_nxt = iter_res[N-1:0];
              ovf_nxt = 1'b0;
            end
            default: begin
              res_nxt = iter_res[2*N-1:N];
              ovf_nxt = 1'b0;
            end
          endcase
        end
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Control and result registers; Zero is derived from the value being latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      Result   <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_ready && in_valid) op_q <= ALUctr;
      if (res_load) begin
        Result   <= res_nxt;
        Zero     <= (res_nxt == '0);
        Overflow <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: scoreboard of expected results checked at out_valid.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUctr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero;
  logic        Overflow;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];

  alu_seq #(.N(32), .CTRW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUctr    (ALUctr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] w;
    logic [63:0] p;
    e.res = 32'd0;
    e.ovf = 1'b0;
    e.lat = 8'd1;
    case (c)
      4'd0: e.res = a + b;
      4'd1: begin w = {a[31], a} + {b[31], b}; e.res = w[31:0]; e.ovf = w[32] ^ w[31]; end
      4'd2: e.res = a - b;
      4'd3: begin w = {a[31], a} - {b[31], b}; e.res = w[31:0]; e.ovf = w[32] ^ w[31]; end
      4'd4: e.res = a | b;
      4'd5: e.res = {31'd0, ($signed(a) < $signed(b))};
      4'd6: e.res = {31'd0, (a < b)};
      4'd7: e.res = a & b;
      4'd8: begin
        p = {32'd0, a} * {32'd0, b};
        e.res = p[31:0]; e.ovf = |p[63:32]; e.lat = 8'd33;
      end
      4'd9:  if (b == 0) begin e.res = 32'hFFFF_FFFF; e.ovf = 1'b1; end
             else begin e.res = a / b; e.lat = 8'd33; end
      4'd10: if (b == 0) begin e.res = a; e.ovf = 1'b1; end
             else begin e.res = a % b; e.lat = 8'd33; end
      default: e.res = 32'd0;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid after the accept edge, then pop and compare.
  task automatic wait_and_compare(input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
      chk({tag, "_res"}, 64'(Result), 64'(e.res));
      chk({tag, "_zero"}, 64'(Zero), 64'(e.zero));
      chk({tag, "_ovf"}, 64'(Overflow), 64'(e.ovf));
    end
  endtask

  task automatic drain(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    sb.push_back(model(c, a, b));
    @(negedge clk);
    A = a; B = b; ALUctr = c; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALUctr = 4'($urandom_range(0, 15));
    wait_and_compare(tag);
    drain(tag);
  endtask

  initial begin
    int   stale;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALUctr = '0;
    #12;
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(Result), 64'd0);
    chk("rst_flags", 64'({Zero, Overflow}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

    run_op(4'd1, 32'h7FFF_FFFF, 32'd1, "add_ovf");
    run_op(4'd0, 32'h7FFF_FFFF, 32'd1, "addu");
    run_op(4'd3, 32'd5, 32'd5, "sub_zero");
    run_op(4'd3, 32'h8000_0000, 32'd1, "sub_ovf");
    run_op(4'd2, 32'd3, 32'd5, "subu_wrap");
    run_op(4'd5, 32'h8000_0000, 32'd1, "slt_neg");
    run_op(4'd6, 32'h8000_0000, 32'd1, "sltu");
    run_op(4'd5, 32'h8000_0000, 32'h7FFF_FFFF, "slt_subovf");
    run_op(4'd5, 32'h7FFF_FFFF, 32'h8000_0000, "slt_subovf2");
    run_op(4'd4, 32'hF0F0_0000, 32'h0000_0F0F, "or");
    run_op(4'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, "and");
    run_op(4'd12, 32'h1234_5678, 32'h1, "undef");
    run_op(4'd8, 32'h0001_0000, 32'h0001_0000, "mulu_ovf");
    run_op(4'd8, 32'd7, 32'd6, "mulu_small");
    run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_max");
    run_op(4'd9, 32'd100, 32'd7, "divu");
    run_op(4'd10, 32'd100, 32'd7, "remu");
    run_op(4'd9, 32'd9, 32'd0, "divu_by0");
    run_op(4'd10, 32'd9, 32'd0, "remu_by0");
    run_op(4'd9, 32'h8000_0001, 32'h8000_0000, "divu_bigd");
    run_op(4'd10, 32'hFFFF_FFFF, 32'h8000_0001, "remu_bigd");
    run_op(4'd9, 32'hFFFF_FFFF, 32'd1, "divu_one");
    for (int i = 0; i < 3; i++) begin
      run_op(4'd8, $urandom, $urandom, "mulu_rnd");
      run_op(4'd9, $urandom, $urandom_range(1, 32'hFFFF), "divu_rnd");
      run_op(4'd10, $urandom, $urandom_range(1, 32'hFFFF), "remu_rnd");
    end

    // Backpressure: result held in DONE while a new request waits.
    sb.push_back(model(4'd3, 32'd3, 32'd4));
    @(negedge clk);
    A = 32'd3; B = 32'd4; ALUctr = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 32'h0000_00F0; B = 32'h0000_000F; ALUctr = 4'd4;
    chk("bp_first_vld", 64'(out_valid), 64'd1);
    e = model(4'd3, 32'd3, 32'd4);
    wait_and_compare("bp_first");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_res", 64'(Result), 64'(e.res));
      chk("bp_hold_flags", 64'({Zero, Overflow}), 64'({e.zero, e.ovf}));
      chk("bp_hold_vld", 64'(out_valid), 64'd1);
      chk("bp_hold_rdy", 64'(in_ready), 64'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_vld", 64'(out_valid), 64'd0);
    chk("bp_idle_rdy", 64'(in_ready), 64'd1);
    sb.push_back(model(4'd4, 32'h0000_00F0, 32'h0000_000F));
    @(negedge clk); out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_and_compare("bp_pending");
    drain("bp_pending");

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    A = 32'h0001_0000; B = 32'd3; ALUctr = 4'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(out_valid), 64'd0);
    chk("arst_res", 64'(Result), 64'd0);
    chk("arst_flags", 64'({Zero, Overflow}), 64'd0);
    chk("arst_idle", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale++;
    end
    chk("arst_no_stale", 64'(stale), 64'd0);
    run_op(4'd1, 32'd1, 32'd1, "add_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
